// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone arbiters: FSM state encoding and
// priority-mode selectors.
package wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for the N-master to 1-slave Wishbone arbiter. The slave modport is
// the arbiter's view; the master modport is the view of the surrounding bus.
interface wb_rr_arbiter_if #(
    parameter int unsigned N_MST = 2,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned SW    = DW / 8
);
    logic [N_MST-1:0]    m_cyc_i;
    logic [N_MST-1:0]    m_stb_i;
    logic [N_MST-1:0]    m_we_i;
    logic [N_MST*SW-1:0] m_sel_i;
    logic [N_MST*AW-1:0] m_adr_i;
    logic [N_MST*DW-1:0] m_dat_i;
    logic [N_MST-1:0]    m_ack_o;
    logic [N_MST-1:0]    m_err_o;
    logic [DW-1:0]       m_dat_o;

    logic                s_cyc_o;
    logic                s_stb_o;
    logic                s_we_o;
    logic [SW-1:0]       s_sel_o;
    logic [AW-1:0]       s_adr_o;
    logic [DW-1:0]       s_dat_o;
    logic                s_ack_i;
    logic [DW-1:0]       s_dat_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );

endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational winner picker: round-robin from last_idx+1, or lowest index
// when fixed_mode is set. Reusable by any arbiter.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    input  logic          fixed_mode,
    output logic          valid_c,
    output logic [N-1:0]  onehot_c,
    output logic [IW-1:0] idx_c
);

    always_comb begin
        int unsigned base;
        int unsigned k;
        valid_c  = 1'b0;
        onehot_c = '0;
        idx_c    = '0;
        k        = 0;
        base     = fixed_mode ? 0 : (32'(last_idx) + 32'd1) % N;
        for (int unsigned off = 0; off < N; off++) begin
            k = (base + off) % N;
            if (!valid_c && req[k]) begin
                valid_c     = 1'b1;
                onehot_c[k] = 1'b1;
                idx_c       = IW'(k);
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master Wishbone classic arbiter with registered grant and slave watchdog.
// Define WB_ARB_CYC_LOCK_EN to hold the grant across acks while cyc stays high.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned N_MST     = 2,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned SW        = DW / 8,
    parameter int unsigned PRIO_MODE = PRIO_RR,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_rr_arbiter_if.slave   bus,
    output logic [N_MST-1:0] grant_o,
    output logic             busy_o
);

    localparam int unsigned IW = $clog2(N_MST);
    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic [N_MST-1:0]  grant_q;
    logic [IW-1:0]     gidx_q;
    logic [IW-1:0]     last_q;
    logic [CW-1:0]     cnt_q;
    logic [N_MST-1:0]  err_q;

    logic [N_MST-1:0]  req;
    logic              pick_valid;
    logic [N_MST-1:0]  pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              cyc_g;
    logic              ack_rel;
    logic              tmo_hit;
    logic              rel;
    logic              tmo;

    logic              s_cyc, s_stb, s_we;
    logic [SW-1:0]     s_sel;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat;
    logic [N_MST-1:0]  m_ack;

    assign req     = bus.m_cyc_i & bus.m_stb_i;
    assign cyc_g   = |(bus.m_cyc_i & grant_q);
    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

`ifdef WB_ARB_CYC_LOCK_EN
    assign ack_rel = 1'b0;
`else
    assign ack_rel = bus.s_ack_i;
`endif

    rr_pick #(.N(N_MST), .IW(IW)) u_pick (
        .req        (req),
        .last_idx   (last_q),
        .fixed_mode (PRIO_MODE == PRIO_FIXED),
        .valid_c    (pick_valid),
        .onehot_c   (pick_oh),
        .idx_c      (pick_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    // Next state; BUSY events ranked ack > abort > timeout
    always_comb begin
        state_d = state_q;
        rel     = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            ARB_IDLE: if (pick_valid) state_d = ARB_BUSY;
            ARB_BUSY: begin
                if (ack_rel || !cyc_g) begin
                    rel = 1'b1;
                end else if (!bus.s_ack_i && tmo_hit) begin
                    rel = 1'b1;
                    tmo = 1'b1;
                end
                if (rel) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Grant, round-robin pointer, watchdog counter and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(N_MST - 1);
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            err_q <= '0;
            if (state_q == ARB_IDLE) begin
                cnt_q <= '0;
                if (pick_valid) begin
                    grant_q <= pick_oh;
                    gidx_q  <= pick_idx;
                end
            end else if (rel) begin
                grant_q <= '0;
                last_q  <= gidx_q;
                cnt_q   <= '0;
                if (tmo) err_q <= grant_q;
            end else if (bus.s_ack_i) begin
                cnt_q <= '0;
            end else if (TIMEOUT != 0) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Outputs: slave mirrors the granted master while BUSY, zero otherwise
    always_comb begin
        s_cyc = 1'b0;
        s_stb = 1'b0;
        s_we  = 1'b0;
        s_sel = '0;
        s_adr = '0;
        s_dat = '0;
        m_ack = '0;
        if (state_q == ARB_BUSY) begin
            m_ack = bus.s_ack_i ? grant_q : '0;
            for (int unsigned k = 0; k < N_MST; k++) begin
                if (grant_q[k]) begin
                    s_cyc = bus.m_cyc_i[k];
                    s_stb = bus.m_stb_i[k];
                    s_we  = bus.m_we_i[k];
                    s_sel = bus.m_sel_i[k*SW +: SW];
                    s_adr = bus.m_adr_i[k*AW +: AW];
                    s_dat = bus.m_dat_i[k*DW +: DW];
                end
            end
        end
    end

    assign bus.s_cyc_o = s_cyc;
    assign bus.s_stb_o = s_stb;
    assign bus.s_we_o  = s_we;
    assign bus.s_sel_o = s_sel;
    assign bus.s_adr_o = s_adr;
    assign bus.s_dat_o = s_dat;
    assign bus.m_ack_o = m_ack;
    assign bus.m_err_o = err_q;
    assign bus.m_dat_o = bus.s_dat_i;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q == ARB_BUSY);

endmodule
